// File: rtl/freq_sweep_scheduler_pkg.sv
// Shared definitions for the frequency sweep scheduler: state encoding,
// default sweep geometry and the watchdog limit.
package freq_sweep_scheduler_pkg;

  localparam int FREQ_NUM_DEF       = 257;
  localparam int FREQ_W_DEF         = 9;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_GAP,
    ST_FINISH,
    ST_ERROR
  } state_t;

  function automatic logic is_busy(input state_t s);
    return !((s == ST_IDLE) || (s == ST_ERROR));
  endfunction

endpackage

// File: rtl/sweep_watchdog.sv
// Per-phase watchdog: counts cycles since the last restart while enabled and
// flags expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
module sweep_watchdog
  import freq_sweep_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [CNT_W-1:0] cnt;

  // A zero limit disables the watchdog entirely.
  assign expired = (TIMEOUT_CYCLES != 0) && enable && (cnt == LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/freq_sweep_scheduler.sv
// Steps the inverse datapath through FREQ_NUM frequency bins, one start pulse
// per bin, with a watchdog on each handshake phase and host abort/clear.
module freq_sweep_scheduler
  import freq_sweep_scheduler_pkg::*;
#(
  parameter int FREQ_NUM       = FREQ_NUM_DEF,
  parameter int FREQ_W         = FREQ_W_DEF,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sweep_go,
  input  logic              abort,
  input  logic              clr_err,
  input  logic              inv_done,
  input  logic              inv_all_freq_finish,
  output logic              inv_start,
  output logic [FREQ_W-1:0] freq_idx,
  output logic              busy,
  output logic              sweep_done,
  output logic              err_timeout,
  output logic              err_finish_mismatch
);

  localparam logic [FREQ_W-1:0] LAST_IDX = FREQ_W'(FREQ_NUM - 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // GAP_CYCLES of 0 or 1 both leave GAP after a single cycle.
  localparam logic [GAP_W-1:0] GAP_LAST =
    (GAP_CYCLES > 1) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_t           state, next_state;
  logic [GAP_W-1:0] gap_cnt;
  logic             wd_restart, wd_enable, wd_expired;
  logic             aborting;

  assign aborting   = abort && is_busy(state);
  assign wd_enable  = (state == ST_WAIT_LOW) || (state == ST_WAIT_HIGH);
  assign wd_restart = (next_state != state) &&
                      ((next_state == ST_WAIT_LOW) || (next_state == ST_WAIT_HIGH));

  sweep_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .restart(wd_restart),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  // NOTE: next_state gets its default before the case so no path through the
  // block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (sweep_go && !abort) next_state = ST_ISSUE;
      ST_ISSUE:     next_state = ST_WAIT_LOW;
      ST_WAIT_LOW: begin
        if (!inv_done)       next_state = ST_WAIT_HIGH;
        else if (wd_expired) next_state = ST_ERROR;
      end
      ST_WAIT_HIGH: begin
        if (inv_done)        next_state = (freq_idx == LAST_IDX) ? ST_FINISH : ST_GAP;
        else if (wd_expired) next_state = ST_ERROR;
      end
      ST_GAP:       if (gap_cnt == GAP_LAST) next_state = ST_ISSUE;
      ST_FINISH:    next_state = ST_IDLE;
      ST_ERROR:     if (clr_err) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
    // Abort overrides every other transition, including watchdog expiry.
    if (aborting) next_state = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= ST_IDLE;
      gap_cnt             <= '0;
      freq_idx            <= '0;
      inv_start           <= 1'b0;
      busy                <= 1'b0;
      sweep_done          <= 1'b0;
      err_timeout         <= 1'b0;
      err_finish_mismatch <= 1'b0;
    end else begin
      state      <= next_state;
      busy       <= is_busy(next_state);
      inv_start  <= (state == ST_ISSUE) && !abort;
      sweep_done <= (state == ST_FINISH) && !abort;
      gap_cnt    <= ((state == ST_GAP) && (next_state == ST_GAP)) ? gap_cnt + 1'b1 : '0;

      // Every return to IDLE (finish, abort, error clear) rewinds the index.
      if (next_state == ST_IDLE) begin
        freq_idx <= '0;
      end else if ((state == ST_WAIT_HIGH) && (next_state == ST_GAP)) begin
        freq_idx <= freq_idx + 1'b1;
      end

      if (next_state == ST_ERROR) begin
        err_timeout <= 1'b1;
      end else if (state == ST_ERROR) begin
        err_timeout <= 1'b0;
      end

      if ((state == ST_IDLE) && (next_state == ST_ISSUE)) begin
        err_finish_mismatch <= 1'b0;
      end else if ((state == ST_FINISH) && !abort && !inv_all_freq_finish) begin
        err_finish_mismatch <= 1'b1;
      end
    end
  end

endmodule
